spm_pipe_mult: RTL and testbench

- Parametrised successor to the fixed-width spm serial-parallel multiplier.
- Controller FSM plus carry-save adder (csa) array of WIDTH cells.
- Accepts a parallel operand pair on a start handshake and serialises y LSB-first into the csa array.
- Emits the 2*WIDTH-bit product serially (p, p_valid) and in parallel (product, done); adds abort and back-to-back operation.

---
 rtl/spm_pipe_mult_if.sv | 27 ++
 rtl/spm_pipe_mult.sv | 166 ++++++++++++++++
 tb/tb_spm_pipe_mult.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spm_pipe_mult_if.sv
// spm_pipe_mult_if: operand/result bundle for the serial-parallel multiplier.
//   master (requester) drives start, clr, x, y.
//   slave  (multiplier) drives ready, busy, p, p_valid, product, done.
interface spm_pipe_mult_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               clr;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               ready;
  logic               busy;
  logic               p;
  logic               p_valid;
  logic [2*WIDTH-1:0] product;
  logic               done;

  modport master (
    output start, clr, x, y,
    input  ready, busy, p, p_valid, product, done
  );

  modport slave (
    input  start, clr, x, y,
    output ready, busy, p, p_valid, product, done
  );
endinterface

// File: rtl/spm_pipe_mult.sv
// spm_pipe_mult: serial-parallel multiplier. x is held in parallel, y is fed
// LSB-first into a WIDTH-cell carry-save array, one product bit per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : spm_pipe_mult_if.slave
//              start/clr/x/y in; ready/busy, serial p/p_valid,
//              parallel product/done out
// Build option: define SPM_SIGNED_EN for two's-complement operands.

// One carry-save cell. TCMP turns it into a serial two's complementer, used
// for the negatively weighted sign bit of x.
module spm_csa_cell #(
  parameter bit TCMP = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic s_in,
  output logic s_nxt,
  output logic s_q
);
  logic c_q, c_nxt;

  generate
    if (TCMP) begin : g_tcmp
      // s_in is always 0 for the top cell; the state bit records
      // "a 1 has been seen", so the output stream is -A.
      assign s_nxt = a ^ s_in ^ c_q;
      assign c_nxt = a | c_q;
    end else begin : g_fa
      assign s_nxt = a ^ s_in ^ c_q;
      assign c_nxt = (a & s_in) | (a & c_q) | (s_in & c_q);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (clr) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (en) begin
      s_q <= s_nxt;
      c_q <= c_nxt;
    end
  end
endmodule

module spm_pipe_mult #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(2*WIDTH+1)
) (
  input logic           clk,
  input logic           rst,
  spm_pipe_mult_if.slave bus
);
`ifdef SPM_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2*WIDTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic               accept, step, finish, abort;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [2*WIDTH-1:0] acc_q, product_q;
  logic               p_valid_q, done_q;
  logic [WIDTH-1:0]   a, s_in, s_nxt, s_q;
  logic               y_ext;

  // Next state / control strobes. clr wins over start and over completion.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (bus.start && !bus.clr) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (bus.clr) begin
        abort   = 1'b1;
        state_d = IDLE;
      end else if (cnt_q == LAST) begin
        // last bit left the array on the previous edge
        finish  = 1'b1;
        state_d = IDLE;
      end else begin
        step    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // y shifts right; once its own bits are used up the fill bit is the
  // extension (sign bit in the signed build, which is replicated in place).
  assign y_ext = SIGNED_EN ? y_q[WIDTH-1] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      p_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      p_valid_q <= step;
      done_q    <= finish;
      if (accept) begin
        x_q   <= bus.x;
        y_q   <= bus.y;
        cnt_q <= '0;
        acc_q <= '0;
      end else if (abort) begin
        cnt_q <= '0;
      end else if (step) begin
        y_q   <= {y_ext, y_q[WIDTH-1:1]};
        cnt_q <= cnt_q + 1'b1;
        acc_q <= {s_nxt[0], acc_q[2*WIDTH-1:1]};
      end
      if (finish) product_q <= acc_q;
    end
  end

  // csa array: cell i adds x[i]&ybit to the sum arriving from cell i+1.
  assign a    = x_q & {WIDTH{y_q[0]}};
  assign s_in = {1'b0, s_q[WIDTH-1:1]};

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      spm_csa_cell #(.TCMP(SIGNED_EN && (i == WIDTH-1))) u_cell (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept | abort),
        .en   (step),
        .a    (a[i]),
        .s_in (s_in[i]),
        .s_nxt(s_nxt[i]),
        .s_q  (s_q[i])
      );
    end
  endgenerate

  // Cell 0's sum register is exactly the registered serial product bit.
  assign bus.p       = s_q[0];
  assign bus.p_valid = p_valid_q;
  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q == RUN);
endmodule

// File: tb/tb_spm_pipe_mult.sv
// tb_spm_pipe_mult: directed test of spm_pipe_mult at WIDTH=8.
// Expected products follow the build (SPM_SIGNED_EN defined or not).
module tb_spm_pipe_mult;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spm_pipe_mult_if #(.WIDTH(8)) bus ();

  spm_pipe_mult #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef SPM_SIGNED_EN
  localparam logic [15:0] EXP_FFFF = 16'h0001;
  localparam logic [15:0] EXP_807F = 16'hC080;
`else
  localparam logic [15:0] EXP_FFFF = 16'hFE01;
  localparam logic [15:0] EXP_807F = 16'h3F80;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operand pair while ready; the accepting edge is k.
  task automatic issue(input string tag, input logic [7:0] xv, input logic [7:0] yv);
    check({tag, "/ready_at_start"}, 16'(bus.ready), 16'h1);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.y     = yv;
    tick;
    bus.start = 1'b0;
    bus.x     = 8'($urandom);
    bus.y     = 8'($urandom);
  endtask

  // Called in cycle k; follows the run to the done cycle k+17.
  task automatic await_op(input string tag, input logic [15:0] exp,
                          input logic [15:0] prev, input bit inject);
    logic [15:0] ser;
    bit pv_ok, done_early;
    check({tag, "/busy"},      16'(bus.busy),  16'h1);
    check({tag, "/not_ready"}, 16'(bus.ready), 16'h0);
    check({tag, "/done_low"},  16'(bus.done),  16'h0);
    check({tag, "/prev_held"}, bus.product,    prev);
    ser = '0;
    pv_ok = 1'b1;
    done_early = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (inject && i == 3) begin
        bus.start = 1'b1;
        bus.x = 8'h07;
        bus.y = 8'h07;
      end
      if (inject && i == 5) bus.start = 1'b0;
      tick;
      if (bus.p_valid !== 1'b1) pv_ok = 1'b0;
      if (bus.done !== 1'b0) done_early = 1'b1;
      ser[i-1] = bus.p;
    end
    check({tag, "/p_valid_run"}, 16'(pv_ok),      16'h1);
    check({tag, "/no_early_done"}, 16'(done_early), 16'h0);
    check({tag, "/serial"},      ser,             exp);
    check({tag, "/held_to_end"}, bus.product,     prev);
    tick;
    check({tag, "/done"},        16'(bus.done),    16'h1);
    check({tag, "/product"},     bus.product,      exp);
    check({tag, "/ready_done"},  16'(bus.ready),   16'h1);
    check({tag, "/p_valid_off"}, 16'(bus.p_valid), 16'h0);
  endtask

  initial begin
    bit seen_done;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    bus.x     = '0;
    bus.y     = '0;

    // Reset state
    #1;
    check("rst/ready",   16'(bus.ready),   16'h1);
    check("rst/busy",    16'(bus.busy),    16'h0);
    check("rst/p",       16'(bus.p),       16'h0);
    check("rst/p_valid", 16'(bus.p_valid), 16'h0);
    check("rst/product", bus.product,      16'h0);
    check("rst/done",    16'(bus.done),    16'h0);
    tick;
    tick;
    #3 rst = 1'b0;
    tick;

    // Async reset in the middle of a run
    issue("midrst", 8'h55, 8'h33);
    repeat (4) tick;
    #2 rst = 1'b1;
    #1;
    check("midrst/ready",   16'(bus.ready),   16'h1);
    check("midrst/busy",    16'(bus.busy),    16'h0);
    check("midrst/p_valid", 16'(bus.p_valid), 16'h0);
    check("midrst/product", bus.product,      16'h0);
    #1 rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.done !== 1'b0) seen_done = 1'b1;
    end
    check("midrst/no_done",     16'(seen_done), 16'h0);
    check("midrst/ready_after", 16'(bus.ready), 16'h1);

    // Small operands, then all-ones, then back-to-back with busy starts
    issue("op03x05", 8'h03, 8'h05);
    await_op("op03x05", 16'h000F, 16'h0000, 1'b0);
    tick;
    check("op03x05/done_pulse", 16'(bus.done), 16'h0);

    issue("opFFxFF", 8'hFF, 8'hFF);
    await_op("opFFxFF", EXP_FFFF, 16'h000F, 1'b0);
    issue("b2b", 8'h02, 8'h04);
    await_op("b2b", 16'h0008, EXP_FFFF, 1'b1);

    issue("op80x7F", 8'h80, 8'h7F);
    await_op("op80x7F", EXP_807F, 16'h0008, 1'b0);

    // Abort: clr present in cycle k+5, seen at edge k+6
    tick;
    issue("abort", 8'h55, 8'h33);
    repeat (5) tick;
    bus.clr = 1'b1;
    tick;
    bus.clr = 1'b0;
    check("abort/p_valid", 16'(bus.p_valid), 16'h0);
    check("abort/ready",   16'(bus.ready),   16'h1);
    check("abort/busy",    16'(bus.busy),    16'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.done !== 1'b0) seen_done = 1'b1;
    end
    check("abort/no_done", 16'(seen_done), 16'h0);
    check("abort/product", bus.product,    EXP_807F);

    // start together with clr in IDLE is suppressed
    bus.start = 1'b1;
    bus.clr   = 1'b1;
    bus.x     = 8'h09;
    bus.y     = 8'h09;
    tick;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    check("startclr/ready", 16'(bus.ready), 16'h1);
    check("startclr/busy",  16'(bus.busy),  16'h0);
    repeat (3) tick;
    check("startclr/p_valid", 16'(bus.p_valid), 16'h0);

    // A normal run still works after the suppressed start
    issue("after", 8'h0C, 8'h0B);
    await_op("after", 16'h0084, EXP_807F, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
